// File: rtl/mips_pkg.sv
// -----------------------------------------------------------------------------
// mips_pkg
// Shared constants and pipeline-register types for the five-stage MIPS core.
//   RESET_PC_DEFAULT : PC loaded on reset
//   IM_BASE_DEFAULT  : byte address of instruction-memory word 0
//   NOP_INSTR        : encoding used for bubbles and faulted fetches (sll $0,$0,0)
//   if_id_t          : contents of the IF/ID pipeline register
// -----------------------------------------------------------------------------
package mips_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_3000;
    localparam logic [31:0] IM_BASE_DEFAULT  = 32'h0000_3000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
        logic        valid;
        logic        adel;
    } if_id_t;

    localparam if_id_t IF_ID_BUBBLE = '{instr: NOP_INSTR, pc: 32'h0, valid: 1'b0, adel: 1'b0};

endpackage

// File: rtl/if_id_reg.sv
// -----------------------------------------------------------------------------
// if_id_reg
// IF/ID pipeline register with reset > flush > stall priority.
// The same pattern is reused for the D/E register.
// Ports:
//   clk     : system clock
//   reset   : synchronous, active-high; loads a bubble
//   i_flush : load a bubble on the next edge (wins over i_stall)
//   i_stall : hold the current contents
//   i_d     : value captured on an unstalled, unflushed edge
//   o_q     : registered contents
// -----------------------------------------------------------------------------
module if_id_reg
    import mips_pkg::*;
(
    input  logic   clk,
    input  logic   reset,
    input  logic   i_flush,
    input  logic   i_stall,
    input  if_id_t i_d,
    output if_id_t o_q
);

    if_id_t r_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_q <= IF_ID_BUBBLE;
        end else if (i_flush) begin
            r_q <= IF_ID_BUBBLE;
        end else if (!i_stall) begin
            r_q <= i_d;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction-fetch stage: fetch PC register, instruction-memory address
// generation, fetch-address fault detection and the IF/ID register.
// Ports:
//   clk      : system clock, rising edge
//   reset    : synchronous, active-high
//   npc      : next PC from the decode-stage next-PC logic
//   stall    : freeze PC and IF/ID
//   flush_d  : turn IF/ID into a bubble on the next edge (PC unaffected)
//   im_instr : word read combinationally at im_addr
//   pc_f     : current fetch PC
//   im_addr  : word index (pc_f - IM_BASE) >> 2
//   instr_d  : IF/ID instruction
//   pc_d     : IF/ID PC
//   pc8_d    : pc_d + 8 (jal/jalr link value)
//   valid_d  : IF/ID holds a real fetched instruction
//   adel_d   : IF/ID instruction came from a bad fetch address
// -----------------------------------------------------------------------------
module fetch_stage
    import mips_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
    parameter logic [31:0] IM_BASE  = IM_BASE_DEFAULT,
    parameter int          IM_WORDS = 4096
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [31:0]                 npc,
    input  logic                        stall,
    input  logic                        flush_d,
    input  logic [31:0]                 im_instr,
    output logic [31:0]                 pc_f,
    output logic [$clog2(IM_WORDS)-1:0] im_addr,
    output logic [31:0]                 instr_d,
    output logic [31:0]                 pc_d,
    output logic [31:0]                 pc8_d,
    output logic                        valid_d,
    output logic                        adel_d
);

    localparam int          AW       = $clog2(IM_WORDS);
    localparam logic [31:0] IM_BYTES = 32'(IM_WORDS) << 2;

    logic [31:0] r_pc;
    logic [31:0] w_offset;
    logic        w_fault;
    if_id_t      w_ifid_d;
    if_id_t      w_ifid_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc <= RESET_PC;
        end else if (!stall) begin
            r_pc <= npc;
        end
    end

    // A PC below IM_BASE wraps the offset to a large value, so a single
    // unsigned compare covers both ends of the range without overflow.
    assign w_offset = r_pc - IM_BASE;
    assign w_fault  = (r_pc[1:0] != 2'b00) || (w_offset >= IM_BYTES);
    assign im_addr  = w_offset[AW+1:2];

    always_comb begin
        w_ifid_d       = IF_ID_BUBBLE;
        w_ifid_d.instr = w_fault ? NOP_INSTR : im_instr;
        w_ifid_d.pc    = r_pc;
        w_ifid_d.valid = 1'b1;
        w_ifid_d.adel  = w_fault;
    end

    if_id_reg u_if_id_reg (
        .clk     (clk),
        .reset   (reset),
        .i_flush (flush_d),
        .i_stall (stall),
        .i_d     (w_ifid_d),
        .o_q     (w_ifid_q)
    );

    assign pc_f    = r_pc;
    assign instr_d = w_ifid_q.instr;
    assign pc_d    = w_ifid_q.pc;
    assign pc8_d   = w_ifid_q.pc + 32'd8;
    assign valid_d = w_ifid_q.valid;
    assign adel_d  = w_ifid_q.adel;

endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;

    localparam logic [31:0] IM_BASE  = 32'h0000_3000;
    localparam logic [31:0] RESET_PC = 32'h0000_3000;
    localparam int          IM_WORDS = 4096;
    localparam int          AW       = $clog2(IM_WORDS);

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   npc;
    logic          stall;
    logic          flush_d;
    logic [31:0]   im_instr;
    logic [31:0]   pc_f;
    logic [AW-1:0] im_addr;
    logic [31:0]   instr_d;
    logic [31:0]   pc_d;
    logic [31:0]   pc8_d;
    logic          valid_d;
    logic          adel_d;

    int n_checks = 0;
    int n_fails  = 0;

    // reference model state
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_pcd;
    logic        m_valid;
    logic        m_adel;

    fetch_stage #(
        .RESET_PC (RESET_PC),
        .IM_BASE  (IM_BASE),
        .IM_WORDS (IM_WORDS)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .npc      (npc),
        .stall    (stall),
        .flush_d  (flush_d),
        .im_instr (im_instr),
        .pc_f     (pc_f),
        .im_addr  (im_addr),
        .instr_d  (instr_d),
        .pc_d     (pc_d),
        .pc8_d    (pc8_d),
        .valid_d  (valid_d),
        .adel_d   (adel_d)
    );

    always #5 clk = ~clk;

    // instruction memory: word k holds 24000000 + k
    assign im_instr = 32'h2400_0000 + 32'(im_addr);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fails++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit ref_fault(input logic [31:0] pc);
        longint unsigned a;
        a = longint'(pc);
        return (a % 4 != 0) || (a < longint'(IM_BASE)) ||
               (a >= longint'(IM_BASE) + 4 * longint'(IM_WORDS));
    endfunction

    function automatic logic [31:0] ref_index(input logic [31:0] pc);
        longint unsigned off;
        off = (longint'(pc) + 64'h1_0000_0000 - longint'(IM_BASE)) % 64'h1_0000_0000;
        return 32'((off / 4) % IM_WORDS);
    endfunction

    task automatic model_step(input logic r, input logic s, input logic f, input logic [31:0] n);
        logic        flt;
        logic [31:0] word;
        flt  = ref_fault(m_pc);
        word = flt ? 32'h0 : (32'h2400_0000 + ref_index(m_pc));
        if (r) begin
            m_pc = RESET_PC;
            m_instr = 0; m_pcd = 0; m_valid = 0; m_adel = 0;
        end else begin
            if (f) begin
                m_instr = 0; m_pcd = 0; m_valid = 0; m_adel = 0;
            end else if (!s) begin
                m_instr = word; m_pcd = m_pc; m_valid = 1; m_adel = flt;
            end
            if (!s) m_pc = n;
        end
    endtask

    task automatic check_all();
        check("pc_f",    pc_f,           m_pc);
        check("im_addr", 32'(im_addr),   ref_index(m_pc));
        check("instr_d", instr_d,        m_instr);
        check("pc_d",    pc_d,           m_pcd);
        check("pc8_d",   pc8_d,          m_pcd + 32'd8);
        check("valid_d", 32'(valid_d),   32'(m_valid));
        check("adel_d",  32'(adel_d),    32'(m_adel));
    endtask

    // drive inputs away from the edge, clock once, update model, compare
    task automatic cycle(input logic r, input logic s, input logic f, input logic [31:0] n);
        reset = r; stall = s; flush_d = f; npc = n;
        @(posedge clk);
        model_step(r, s, f, n);
        #1;
        check_all();
    endtask

    initial begin
        logic [31:0] held_pc;
        logic [31:0] held_instr;
        logic [31:0] rn;
        int          sel;

        m_pc = 32'hDEAD_BEEF;
        m_instr = 0; m_pcd = 0; m_valid = 0; m_adel = 0;
        reset = 1; stall = 0; flush_d = 0; npc = 32'h0;
        @(posedge clk); #1;

        // reset state
        cycle(1, 0, 0, 32'h0);
        cycle(1, 0, 0, 32'h0);
        check("rst_pc_f",    pc_f,         32'h0000_3000);
        check("rst_im_addr", 32'(im_addr), 32'h0);
        check("rst_pc8_d",   pc8_d,        32'h8);
        check("rst_valid",   32'(valid_d), 32'h0);

        // sequential fetch
        cycle(0, 0, 0, m_pc + 4);
        check("seq_pc_f1", pc_f,    32'h0000_3004);
        check("seq_inst1", instr_d, 32'h2400_0000);
        cycle(0, 0, 0, m_pc + 4);
        check("seq_pc_f2", pc_f,    32'h0000_3008);
        check("seq_pc8_d", pc8_d,   32'h0000_300C);
        cycle(0, 0, 0, m_pc + 4);
        check("seq_pc_f3", pc_f,    32'h0000_300C);

        // 3-cycle stall at 300C
        held_pc    = pc_d;
        held_instr = instr_d;
        for (int i = 0; i < 3; i++) begin
            cycle(0, 1, 0, m_pc + 4);
            check("stall_pc_f",  pc_f,    32'h0000_300C);
            check("stall_pc_d",  pc_d,    held_pc);
            check("stall_instr", instr_d, held_instr);
        end
        cycle(0, 0, 0, m_pc + 4);
        check("rel_pc_f",  pc_f,    32'h0000_3010);
        check("rel_instr", instr_d, 32'h2400_0003);
        check("rel_pc_d",  pc_d,    32'h0000_300C);

        // stall + flush at 3010
        cycle(0, 1, 1, m_pc + 4);
        check("sf_pc_f",  pc_f,         32'h0000_3010);
        check("sf_instr", instr_d,      32'h0);
        check("sf_valid", 32'(valid_d), 32'h0);
        check("sf_pc8_d", pc8_d,        32'h8);

        // misaligned fetch
        cycle(0, 0, 0, 32'h0000_3002);
        cycle(0, 0, 0, 32'h0000_7000);
        check("mis_adel",  32'(adel_d),  32'h1);
        check("mis_instr", instr_d,      32'h0);
        check("mis_pc_d",  pc_d,         32'h0000_3002);
        check("mis_valid", 32'(valid_d), 32'h1);

        // range boundaries
        cycle(0, 0, 0, 32'h0000_2FFC);
        check("end_adel", 32'(adel_d), 32'h1);
        cycle(0, 0, 0, 32'h0000_6FFC);
        check("low_adel", 32'(adel_d), 32'h1);
        cycle(0, 0, 0, 32'h0000_3040);
        check("last_adel",  32'(adel_d), 32'h0);
        check("last_instr", instr_d,     32'h2400_0FFF);

        // reset during stall at 3040
        cycle(0, 1, 0, 32'h0000_5000);
        check("pre_rst_pc_f", pc_f, 32'h0000_3040);
        cycle(1, 1, 1, 32'h0000_5000);
        check("mid_rst_pc_f",  pc_f,         32'h0000_3000);
        check("mid_rst_instr", instr_d,      32'h0);
        check("mid_rst_pc_d",  pc_d,         32'h0);
        check("mid_rst_valid", 32'(valid_d), 32'h0);
        check("mid_rst_adel",  32'(adel_d),  32'h0);

        // randomized traffic
        for (int k = 0; k < 2000; k++) begin
            sel = $urandom_range(0, 9);
            case (sel)
                6:       rn = IM_BASE + ($urandom_range(0, IM_WORDS - 1) << 2);
                7:       rn = IM_BASE + ($urandom_range(0, IM_WORDS - 1) << 2) + $urandom_range(1, 3);
                8:       rn = $urandom;
                9: begin
                    case ($urandom_range(0, 3))
                        0:       rn = IM_BASE - 4;
                        1:       rn = IM_BASE + 4 * IM_WORDS;
                        2:       rn = IM_BASE + 4 * IM_WORDS - 4;
                        default: rn = IM_BASE;
                    endcase
                end
                default: rn = m_pc + 4;
            endcase
            cycle(($urandom_range(0, 49) == 0),
                  ($urandom_range(0, 3) == 0),
                  ($urandom_range(0, 9) == 0),
                  rn);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
